// File: rtl/rr_arbiter_lock_if.sv
// rr_arbiter_lock_if: request/lock in, grant out.
// Arbiter side is the slave modport.
interface rr_arbiter_lock_if #(
  parameter int N = 4
);
  localparam int IW = $clog2(N);

  logic [N-1:0]  request;
  logic [N-1:0]  lock;
  logic [N-1:0]  grant;
  logic          grant_valid;
  logic [IW-1:0] grant_id;

  modport master (
    output request,
    output lock,
    input  grant,
    input  grant_valid,
    input  grant_id
  );

  modport slave (
    input  request,
    input  lock,
    output grant,
    output grant_valid,
    output grant_id
  );
endinterface

// File: rtl/rr_arbiter_lock.sv
// rr_arbiter_lock: round-robin arbiter with
// per-requester lock and bounded tenure.
module rr_arbiter_lock #(
  parameter int NO_REQUESTERS = 4,
  parameter int MAX_HOLD      = 16
) (
  input  logic            clock,
  input  logic            reset,
  rr_arbiter_lock_if.slave bus
);
  localparam int N    = NO_REQUESTERS;
  localparam int IW   = $clog2(N);
  localparam int TW   = (MAX_HOLD > 0) ?
                        $clog2(MAX_HOLD + 1) : 1;
  localparam int TSAT = (MAX_HOLD > 0) ?
                        MAX_HOLD : 1;

  logic [N-1:0]  grant_q, grant_d;
  logic          gv_q, gv_d;
  logic [IW-1:0] gid_q, gid_d;
  logic [IW-1:0] p_q, p_d;
  logic [TW-1:0] t_q, t_d;

  logic          found;
  logic [IW-1:0] pick;
  logic [IW-1:0] idx;
  int            j;
  logic          expired;
  logic          hold;
  logic [TW-1:0] t_inc;

  assign bus.grant       = grant_q;
  assign bus.grant_valid = gv_q;
  assign bus.grant_id    = gid_q;

  // First requester at or after P, wrapping.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    j     = 0;
    for (int i = 0; i < N; i++) begin
      j = int'(p_q) + i;
      if (j >= N) j = j - N;
      idx = IW'(j);
      if (!found && bus.request[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  // Hold/re-arbitrate decision and tenure count.
  always_comb begin
    expired = (MAX_HOLD != 0) &&
              (t_q == TW'(TSAT));
    hold    = gv_q && bus.request[gid_q] &&
              bus.lock[gid_q] && !expired;
    t_inc   = (t_q == TW'(TSAT)) ?
              t_q : t_q + 1'b1;
    grant_d = grant_q;
    gv_d    = gv_q;
    gid_d   = gid_q;
    p_d     = p_q;
    t_d     = t_q;
    if (hold) begin
      t_d = t_inc;
    end else if (found) begin
      grant_d       = '0;
      grant_d[pick] = 1'b1;
      gv_d          = 1'b1;
      gid_d         = pick;
      p_d = (pick == IW'(N - 1)) ?
            '0 : pick + 1'b1;
      t_d = (gv_q && pick == gid_q) ?
            t_inc : TW'(1);
    end else begin
      grant_d = '0;
      gv_d    = 1'b0;
      gid_d   = '0;
      t_d     = '0;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      grant_q <= '0;
      gv_q    <= 1'b0;
      gid_q   <= '0;
      p_q     <= '0;
      t_q     <= '0;
    end else begin
      grant_q <= grant_d;
      gv_q    <= gv_d;
      gid_q   <= gid_d;
      p_q     <= p_d;
      t_q     <= t_d;
    end
  end
endmodule

// File: doc/rr_arbiter_lock.md
# rr_arbiter_lock

Parametrised round-robin arbiter with registered one-hot grant, per-requester lock (burst/frame hold) and a bounded-tenure timeout. It is the generalised successor to the fixed 4-way arbiter. Rotation is driven by the last granted requester, not a free-running counter, so an idle requester never wastes a slot. It sits in front of the shared MAC TX datapath and buffer-memory port, where clients hold the grant for a full frame.

## Interface
- NO_REQUESTERS, 4: number of requesters N, 2..32.
- MAX_HOLD, 16: maximum consecutive grant cycles while others wait; 0 disables the timeout.
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- request  in  N  per-requester request, level-sensitive.
- lock  in  N  per-requester hold; only meaningful for the currently granted index.
- grant  out  N  registered one-hot grant; all-zero when idle.
- grant_valid  out  1  OR of grant, registered.
- grant_id  out  $clog2(N)  binary index of grant; valid only when grant_valid=1.

## Operation
- State:
  - grant register (g, grant_valid).
  - pointer P, width $clog2(N).
  - tenure counter T, width $clog2(MAX_HOLD+1), saturating.
- Reset values: grant=0, grant_valid=0, grant_id=0, P=0, T=0.
- Decision at every rising edge, using current request, lock, g and T:
  - Hold: grant_valid, request[g], lock[g] and not expired -> keep g; T increments (saturating).
  - Expired: MAX_HOLD!=0 and T==MAX_HOLD.
  - Otherwise, if any request: new grant = first requesting index in search order P, P+1, ..., N-1, 0, ..., P-1.
  - P = (last granted id + 1) mod N, updated whenever a grant is issued. The current holder is therefore searched last.
  - If the new grant equals the old g with grant_valid=1 (sole requester), T keeps counting, saturated. Otherwise T=1.
  - No request: grant=0, grant_valid=0, T=0, P retained.
- Without lock, continuously requesting clients rotate one cycle each. A sole requester keeps the grant every cycle.
- Lock on a non-granted index has no effect.
- Expiry overrides lock only when another requester is pending. The holder is then placed last in the search order, so it is re-granted only if it is alone.
- Grant may move directly from one requester to another with no idle cycle.

## Timing
- Latency: request asserted in cycle t (grant idle) -> grant visible in cycle t+1.
- Release: holder drops request or lock in cycle t -> next grant (or idle) in cycle t+1.
- Max tenure with others waiting: MAX_HOLD cycles. The other requester is granted in cycle t+MAX_HOLD, where t is the first grant cycle.
- Wrap-around: with P=N-1 and requests at 0 and N-1, index N-1 is granted first and P becomes 0.
- Simultaneous release by the holder and new requests in the same cycle: the new requests are arbitrated in that same decision.
- Reset mid-grant: all outputs return to reset values in the next cycle. P=0, so index 0 has first priority after reset.
- grant, grant_valid and grant_id are always mutually consistent. Exactly one grant bit is set or none; never more.

## Test plan
- Reset with request=4'b1111 held: grant=0 during reset. After release, grants are 4'b0001, 0010, 0100, 1000, 0001 on successive cycles with lock=0.
- request=4'b1010 from P=0, no lock: grant_id alternates 1, 3, 1, 3. Dropping request[3] leaves grant_id=1 every cycle.
- req0 with lock0=1 for 6 cycles and req2 pending, MAX_HOLD=16: grant0 for 6 cycles, then grant2 in the cycle after lock0 falls.
- MAX_HOLD=4, req0+lock0 permanently high, req1 asserted from the first grant cycle: grant0 for exactly 4 cycles, then grant1, then grant0 again.
- MAX_HOLD=4, req0+lock0 alone for 20 cycles: grant0 continuous, no dropout.
- Reset asserted for 1 cycle while grant_id=2 with lock: next cycle grant=0. Following cycle with request=4'b0110: grant_id=1.
